// File: rtl/ex_stage_mdu_if.sv
// Execute-stage bundle: decoded instruction, operands and forwarding selects from ID/EX
// in; ALU result, store data, branch redirect and the front-end stall out.
interface ex_stage_mdu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_addr;
  logic [XLEN-1:0] read_data_1;
  logic [XLEN-1:0] read_data_2;
  logic [XLEN-1:0] imm;
  logic            ALUSrc;
  logic            Branch;
  logic            Jump;
  logic [1:0]      ForwardA;
  logic [1:0]      ForwardB;
  logic [XLEN-1:0] forwarding_EX_MEM;
  logic [XLEN-1:0] forwarding_MEM_WB;
  logic            ex_flush;
  logic [XLEN-1:0] ALU_result;
  logic            result_valid;
  logic [XLEN-1:0] read_reg_2_with_forwarding;
  logic [XLEN-1:0] branch_addr;
  logic            PCSrc;
  logic            IF_flush;
  logic            ID_flush;
  logic            ex_stall;

  modport master (
    output in_valid, inst, inst_addr, read_data_1, read_data_2, imm,
           ALUSrc, Branch, Jump, ForwardA, ForwardB,
           forwarding_EX_MEM, forwarding_MEM_WB, ex_flush,
    input  ALU_result, result_valid, read_reg_2_with_forwarding, branch_addr,
           PCSrc, IF_flush, ID_flush, ex_stall
  );

  modport slave (
    input  in_valid, inst, inst_addr, read_data_1, read_data_2, imm,
           ALUSrc, Branch, Jump, ForwardA, ForwardB,
           forwarding_EX_MEM, forwarding_MEM_WB, ex_flush,
    output ALU_result, result_valid, read_reg_2_with_forwarding, branch_addr,
           PCSrc, IF_flush, ID_flush, ex_stall
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and an
// iterative RV32M unit (radix-2^MUL_BITS_CYC multiply, restoring divide).
module ex_stage_mdu #(
  parameter int XLEN         = 32,
  parameter int MUL_BITS_CYC = 2,
  parameter int ENABLE_M     = 1
) (
  input logic           clk,
  input logic           rst_n,
  ex_stage_mdu_if.slave ex
);
  localparam int NMUL = XLEN / MUL_BITS_CYC;
  localparam int CW   = $clog2(XLEN + 1);
  localparam int SW   = $clog2(XLEN);
  localparam bit M_EN = (ENABLE_M != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       is_mop;
  logic       unused_inst;

  assign opcode      = ex.inst[6:0];
  assign f3          = ex.inst[14:12];
  assign f7          = ex.inst[31:25];
  assign is_mop      = (opcode == OP_R) && (f7 == 7'b0000001);
  assign unused_inst = ^{ex.inst[24:15], ex.inst[11:7]};

  // ---------------- forwarding: EX/MEM beats MEM/WB ----------------
  logic [XLEN-1:0] fwd_a, fwd_b, opb;

  always_comb begin
    case (ex.ForwardA)
      2'b10:   fwd_a = ex.forwarding_EX_MEM;
      2'b01:   fwd_a = ex.forwarding_MEM_WB;
      default: fwd_a = ex.read_data_1;
    endcase
    case (ex.ForwardB)
      2'b10:   fwd_b = ex.forwarding_EX_MEM;
      2'b01:   fwd_b = ex.forwarding_MEM_WB;
      default: fwd_b = ex.read_data_2;
    endcase
  end

  assign opb = ex.ALUSrc ? ex.imm : fwd_b;

  // ---------------- single-cycle ALU ----------------
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;

  assign shamt = opb[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_R, OP_I: begin
        if (is_mop) alu_res = '0;
        else begin
          case (f3)
            // only R-type uses bit 30 to select SUB; on ADDI it is an immediate bit
            3'b000:  alu_res = (opcode == OP_R && f7[5]) ? fwd_a - opb : fwd_a + opb;
            3'b001:  alu_res = fwd_a << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(opb))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (fwd_a < opb)};
            3'b100:  alu_res = fwd_a ^ opb;
            3'b101:  alu_res = f7[5] ? $unsigned($signed(fwd_a) >>> shamt) : fwd_a >> shamt;
            3'b110:  alu_res = fwd_a | opb;
            default: alu_res = fwd_a & opb;
          endcase
        end
      end
      OP_LUI:          alu_res = ex.imm;
      OP_AUIPC:        alu_res = ex.inst_addr + ex.imm;
      OP_JAL, OP_JALR: alu_res = ex.inst_addr + XLEN'(4);
      OP_BR:           alu_res = '0;
      default:         alu_res = fwd_a + opb;
    endcase
  end

  // ---------------- branch resolution ----------------
  logic            take;
  logic [XLEN-1:0] jalr_sum;

  always_comb begin
    case (f3)
      3'b000:  take = (fwd_a == fwd_b);
      3'b001:  take = (fwd_a != fwd_b);
      3'b100:  take = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  take = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  take = (fwd_a <  fwd_b);
      3'b111:  take = (fwd_a >= fwd_b);
      default: take = 1'b0;
    endcase
  end

  assign jalr_sum       = fwd_a + ex.imm;
  assign ex.branch_addr = (opcode == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                              : ex.inst_addr + ex.imm;

  // ---------------- M-unit state ----------------
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // MUL: product; DIV: partial remainder
  logic [2*XLEN-1:0] a_q, a_d;       // MUL: shifted multiplicand; DIV: dividend/quotient
  logic [XLEN-1:0]   b_q, b_d;       // MUL: shifting multiplier; DIV: divisor
  logic [XLEN-1:0]   res_q, res_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;

  logic start_raw, start, busy;
  assign start_raw = M_EN && (state_q == S_IDLE) && ex.in_valid && is_mop;
  assign start     = start_raw && !ex.ex_flush;
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);

  // operand signedness and magnitudes at capture
  logic            sa, sb, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    if (f3[2]) begin
      sa = ~f3[0];
      sb = ~f3[0];
    end else begin
      sa = (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
      sb = (f3[1:0] == 2'b01);
    end
  end

  assign a_neg    = sa & fwd_a[XLEN-1];
  assign b_neg    = sb & fwd_b[XLEN-1];
  assign mag_a    = a_neg ? -fwd_a : fwd_a;
  assign mag_b    = b_neg ? -fwd_b : fwd_b;
  assign div_zero = (fwd_b == '0);
  assign div_ovf  = sa && (fwd_a == {1'b1, {(XLEN-1){1'b0}}}) && (fwd_b == '1);

  // multiply step: add MUL_BITS_CYC partial products
  logic [2*XLEN-1:0] mul_pp, mul_acc, prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_pp = '0;
    for (int j = 0; j < MUL_BITS_CYC; j++)
      if (b_q[j]) mul_pp = mul_pp + (a_q << j);
  end

  assign mul_acc = acc_q + mul_pp;
  assign prod    = neg_q ? -mul_acc : mul_acc;
  assign mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // restoring divide step
  logic [XLEN:0]   rem_sh, rem_diff, rem_n;
  logic [XLEN-1:0] quo_n, rem_lo, div_res;
  logic            ge;

  assign rem_sh   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign ge       = ~rem_diff[XLEN];
  assign rem_n    = ge ? rem_diff : rem_sh;
  assign quo_n    = {a_q[XLEN-2:0], ge};
  assign rem_lo   = rem_n[XLEN-1:0];
  assign div_res  = f3_q[1] ? (rneg_q ? -rem_lo : rem_lo) : (neg_q ? -quo_n : quo_n);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: if (start) begin
        f3_d   = f3;
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        cnt_d  = '0;
        acc_d  = '0;
        a_d    = {{XLEN{1'b0}}, mag_a};
        b_d    = mag_b;
        if (!f3[2]) state_d = S_MUL;
        else if (div_zero) begin
          state_d = S_DONE;
          res_d   = f3[1] ? fwd_a : '1;
        end else if (div_ovf) begin
          state_d = S_DONE;
          res_d   = f3[1] ? '0 : fwd_a;
        end else state_d = S_DIV;
      end
      S_MUL: begin
        acc_d = mul_acc;
        a_d   = a_q << MUL_BITS_CYC;
        b_d   = b_q >> MUL_BITS_CYC;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NMUL - 1)) begin
          state_d = S_DONE;
          res_d   = mul_res;
        end
      end
      S_DIV: begin
        acc_d = {{(XLEN-1){1'b0}}, rem_n};
        a_d   = {{XLEN{1'b0}}, quo_n};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_DONE;
          res_d   = div_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ex.ex_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    ex.result_valid = 1'b0;
    if (state_q == S_DONE)      ex.result_valid = ~ex.ex_flush;
    else if (state_q == S_IDLE) ex.result_valid = ex.in_valid & ~ex.ex_flush & ~start_raw;
  end

  assign ex.ex_stall                   = (busy | start_raw) & ~ex.ex_flush;
  assign ex.ALU_result                 = (state_q == S_DONE) ? res_q : alu_res;
  assign ex.read_reg_2_with_forwarding = fwd_b;
  assign ex.PCSrc                      = ((ex.Branch & take) | ex.Jump) & ex.in_valid & ~ex.ex_stall;
  assign ex.IF_flush                   = ex.PCSrc;
  assign ex.ID_flush                   = ex.PCSrc;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: vector table for single-cycle ops and branches,
// hand sequences for M-op latency, special divides, flush and reset aborts.
module tb_ex_stage_mdu;
  localparam logic [6:0] R = 7'h33, I = 7'h13, LUI = 7'h37, AUIPC = 7'h17;
  localparam logic [6:0] JAL = 7'h6f, JALR = 7'h67, BR = 7'h63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   npass = 0;
  int   ntot = 0;

  always #5 clk = ~clk;

  ex_stage_mdu_if #(.XLEN(32)) bus ();
  ex_stage_mdu #(.XLEN(32), .MUL_BITS_CYC(2), .ENABLE_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .ex(bus));

  typedef struct {
    logic [31:0] inst, pc, rs1, rs2, imm, fex, fwb;
    logic        alusrc, br, jmp;
    logic [1:0]  fa, fb;
    logic        chk_res;
    logic [31:0] exp_res;
    logic        exp_pc;
    logic        chk_ba;
    logic [31:0] exp_ba, exp_rs2;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 10'b0, f3, 5'b0, op};
  endfunction

  function automatic vec_t mkv(
    input logic [31:0] inst, pc, rs1, rs2, imm, input logic alusrc, br, jmp,
    input logic [1:0] fa, fb, input logic [31:0] fex, fwb,
    input logic chk_res, input logic [31:0] exp_res, input logic exp_pc,
    input logic chk_ba, input logic [31:0] exp_ba, exp_rs2);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.alusrc = alusrc; v.br = br; v.jmp = jmp; v.fa = fa; v.fb = fb;
    v.fex = fex; v.fwb = fwb; v.chk_res = chk_res; v.exp_res = exp_res;
    v.exp_pc = exp_pc; v.chk_ba = chk_ba; v.exp_ba = exp_ba; v.exp_rs2 = exp_rs2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.inst = 32'h0; bus.inst_addr = 32'h0;
    bus.read_data_1 = 32'h0; bus.read_data_2 = 32'h0; bus.imm = 32'h0;
    bus.ALUSrc = 1'b0; bus.Branch = 1'b0; bus.Jump = 1'b0;
    bus.ForwardA = 2'b00; bus.ForwardB = 2'b00;
    bus.forwarding_EX_MEM = 32'h0; bus.forwarding_MEM_WB = 32'h0; bus.ex_flush = 1'b0;
  endtask

  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, b,
                           input logic [1:0] fa, input logic [31:0] fex);
    idle_inputs();
    bus.in_valid = 1'b1; bus.inst = enc(7'b0000001, f3, R);
    bus.read_data_1 = a; bus.read_data_2 = b;
    bus.ForwardA = fa; bus.forwarding_EX_MEM = fex;
  endtask

  // Issue an M-op at the next edge and count cycles (C0 = issue cycle) until result_valid.
  task automatic run_mop(input string nm, input logic [2:0] f3, input logic [31:0] a, b,
                         input logic [1:0] fa, input logic [31:0] fex,
                         input int exp_cyc, input logic [31:0] exp);
    int  cyc;
    bit  done, stall_ok;
    @(posedge clk); #1;
    drive_mop(f3, a, b, fa, fex);
    cyc = 0; done = 0; stall_ok = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (bus.result_valid) done = 1;
      else begin
        if (!bus.ex_stall) stall_ok = 0;
        cyc++;
        @(posedge clk); #1;
        // operands must have been captured at C0
        bus.read_data_1 = $urandom; bus.read_data_2 = $urandom;
        bus.forwarding_EX_MEM = $urandom; bus.forwarding_MEM_WB = $urandom;
      end
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " latency"}, cyc, exp_cyc);
    chk({nm, " stall while busy"}, 32'(stall_ok), 32'd1);
    chk({nm, " result"}, bus.ALU_result, exp);
    chk({nm, " stall at done"}, 32'(bus.ex_stall), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   seen;
    idle_inputs();

    vecs.push_back(mkv(enc(7'h00,3'd0,R), 0, 5, 7, 0, 0,0,0, 0,0, 0,0, 1, 32'd12, 0, 0,0, 7));
    vecs.push_back(mkv(enc(7'h20,3'd0,R), 0, 5, 7, 0, 0,0,0, 0,0, 0,0, 1, 32'hFFFFFFFE, 0, 0,0, 7));
    vecs.push_back(mkv(enc(7'h00,3'd2,R), 0, 32'hFFFFFFFF, 1, 0, 0,0,0, 0,0, 0,0, 1, 32'd1, 0, 0,0, 1));
    vecs.push_back(mkv(enc(7'h00,3'd3,R), 0, 32'hFFFFFFFF, 1, 0, 0,0,0, 0,0, 0,0, 1, 32'd0, 0, 0,0, 1));
    vecs.push_back(mkv(enc(7'h20,3'd5,R), 0, 32'h80000000, 4, 0, 0,0,0, 0,0, 0,0, 1, 32'hF8000000, 0, 0,0, 4));
    vecs.push_back(mkv(enc(7'h00,3'd5,R), 0, 32'h80000000, 4, 0, 0,0,0, 0,0, 0,0, 1, 32'h08000000, 0, 0,0, 4));
    vecs.push_back(mkv(enc(7'h7f,3'd0,I), 0, 10, 3, 32'hFFFFFFFF, 1,0,0, 0,0, 0,0, 1, 32'd9, 0, 0,0, 3));
    vecs.push_back(mkv(enc(7'h00,3'd0,R), 0, 1, 3, 0, 0,0,0, 2'b10,0, 100,50, 1, 32'd103, 0, 0,0, 3));
    vecs.push_back(mkv(enc(7'h00,3'd0,R), 0, 1, 3, 0, 0,0,0, 2'b01,0, 100,50, 1, 32'd53, 0, 0,0, 3));
    vecs.push_back(mkv(enc(7'h00,3'd0,R), 0, 1, 3, 0, 0,0,0, 0,2'b10, 100,50, 1, 32'd101, 0, 0,0, 100));
    vecs.push_back(mkv(enc(7'h00,3'd0,R), 0, 1, 3, 0, 0,0,0, 0,2'b01, 100,50, 1, 32'd51, 0, 0,0, 50));
    vecs.push_back(mkv(enc(7'h00,3'd4,R), 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,0,0, 0,0, 0,0, 1, 32'h0FF00FF0, 0, 0,0, 32'hFF00FF00));
    vecs.push_back(mkv(enc(7'h00,3'd0,LUI), 0, 0, 0, 32'h12345000, 1,0,0, 0,0, 0,0, 1, 32'h12345000, 0, 0,0, 0));
    vecs.push_back(mkv(enc(7'h00,3'd0,AUIPC), 32'h100, 0, 0, 32'h1000, 1,0,0, 0,0, 0,0, 1, 32'h1100, 0, 0,0, 0));
    vecs.push_back(mkv(enc(7'h00,3'd0,JAL), 32'h200, 0, 0, 32'h40, 0,0,1, 0,0, 0,0, 1, 32'h204, 1, 1,32'h240, 0));
    vecs.push_back(mkv(enc(7'h00,3'd0,JALR), 32'h80, 32'h301, 0, 32'h10, 1,0,1, 0,0, 0,0, 1, 32'h84, 1, 1,32'h310, 0));
    vecs.push_back(mkv(enc(7'h00,3'd4,BR), 32'h100, 32'hFFFFFFFF, 1, 32'h20, 0,1,0, 0,0, 0,0, 0, 0, 1, 1,32'h120, 1));
    vecs.push_back(mkv(enc(7'h00,3'd6,BR), 32'h100, 32'hFFFFFFFF, 1, 32'h20, 0,1,0, 0,0, 0,0, 0, 0, 0, 1,32'h120, 1));
    vecs.push_back(mkv(enc(7'h00,3'd0,BR), 32'h100, 5, 5, 32'h20, 0,1,0, 0,0, 0,0, 0, 0, 1, 1,32'h120, 5));
    vecs.push_back(mkv(enc(7'h00,3'd1,BR), 32'h100, 5, 5, 32'h20, 0,1,0, 0,0, 0,0, 0, 0, 0, 1,32'h120, 5));
    vecs.push_back(mkv(enc(7'h00,3'd5,BR), 32'h100, 32'hFFFFFFFF, 1, 32'h20, 0,1,0, 0,0, 0,0, 0, 0, 0, 1,32'h120, 1));
    vecs.push_back(mkv(enc(7'h00,3'd7,BR), 32'h100, 32'hFFFFFFFF, 1, 32'h20, 0,1,0, 0,0, 0,0, 0, 0, 1, 1,32'h120, 1));
    vecs.push_back(mkv(enc(7'h00,3'd0,BR), 32'h100, 5, 9, 32'h20, 0,1,0, 0,2'b10, 5,0, 0, 0, 1, 1,32'h120, 5));
    vecs.push_back(mkv(enc(7'h00,3'd0,BR), 32'h100, 5, 5, 32'h20, 0,0,0, 0,0, 0,0, 0, 0, 0, 0,0, 5));

    // reset state
    #12;
    chk("reset result_valid", 32'(bus.result_valid), 32'd0);
    chk("reset ex_stall", 32'(bus.ex_stall), 32'd0);
    chk("reset PCSrc", 32'(bus.PCSrc), 32'd0);
    chk("reset IF_flush", 32'(bus.IF_flush), 32'd0);
    chk("reset ID_flush", 32'(bus.ID_flush), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(posedge clk); #1;
      idle_inputs();
      bus.in_valid = 1'b1; bus.inst = v.inst; bus.inst_addr = v.pc;
      bus.read_data_1 = v.rs1; bus.read_data_2 = v.rs2; bus.imm = v.imm;
      bus.ALUSrc = v.alusrc; bus.Branch = v.br; bus.Jump = v.jmp;
      bus.ForwardA = v.fa; bus.ForwardB = v.fb;
      bus.forwarding_EX_MEM = v.fex; bus.forwarding_MEM_WB = v.fwb;
      @(negedge clk);
      chk($sformatf("vec%0d result_valid", i), 32'(bus.result_valid), 32'd1);
      chk($sformatf("vec%0d ex_stall", i), 32'(bus.ex_stall), 32'd0);
      chk($sformatf("vec%0d PCSrc", i), 32'(bus.PCSrc), 32'(v.exp_pc));
      chk($sformatf("vec%0d IF_flush", i), 32'(bus.IF_flush), 32'(v.exp_pc));
      chk($sformatf("vec%0d ID_flush", i), 32'(bus.ID_flush), 32'(v.exp_pc));
      chk($sformatf("vec%0d rs2 fwd", i), bus.read_reg_2_with_forwarding, v.exp_rs2);
      if (v.chk_res) chk($sformatf("vec%0d ALU_result", i), bus.ALU_result, v.exp_res);
      if (v.chk_ba)  chk($sformatf("vec%0d branch_addr", i), bus.branch_addr, v.exp_ba);
    end

    // M-ops back to back; each accepted the cycle after the previous DONE
    run_mop("MUL",     3'd0, 32'd7, 32'hFFFFFFFD, 2'b00, 0, 17, 32'hFFFFFFEB);
    run_mop("MULHU",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 17, 32'hFFFFFFFE);
    run_mop("MULH",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 17, 32'h00000000);
    run_mop("MULHSU",  3'd2, 32'hFFFFFFFF, 32'd2, 2'b00, 0, 17, 32'hFFFFFFFF);
    run_mop("MUL fwd", 3'd0, 32'd9, 32'd5, 2'b10, 32'd6, 17, 32'd30);
    run_mop("DIV",     3'd4, 32'hFFFFFFF9, 32'd2, 2'b00, 0, 33, 32'hFFFFFFFD);
    run_mop("REM",     3'd6, 32'hFFFFFFF9, 32'd2, 2'b00, 0, 33, 32'hFFFFFFFF);
    run_mop("DIVU",    3'd5, 32'd100, 32'd7, 2'b00, 0, 33, 32'd14);
    run_mop("REMU",    3'd7, 32'd100, 32'd7, 2'b00, 0, 33, 32'd2);
    run_mop("DIVU0",   3'd5, 32'd5, 32'd0, 2'b00, 0, 1, 32'hFFFFFFFF);
    run_mop("REM0",    3'd6, 32'd5, 32'd0, 2'b00, 0, 1, 32'd5);
    run_mop("DIVOVF",  3'd4, 32'h80000000, 32'hFFFFFFFF, 2'b00, 0, 1, 32'h80000000);
    run_mop("REMOVF",  3'd6, 32'h80000000, 32'hFFFFFFFF, 2'b00, 0, 1, 32'h00000000);
    @(posedge clk); #1; idle_inputs();

    // flush at C10 of a DIV; an ADD follows in C11
    @(posedge clk); #1;
    drive_mop(3'd4, 32'hFFFFFFF9, 32'd2, 2'b00, 0);
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    bus.ex_flush = 1'b1;
    @(negedge clk);
    chk("flush C10 result_valid", 32'(bus.result_valid), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    bus.in_valid = 1'b1; bus.inst = enc(7'h00, 3'd0, R);
    bus.read_data_1 = 32'd3; bus.read_data_2 = 32'd4;
    @(negedge clk);
    chk("flush C11 ADD valid", 32'(bus.result_valid), 32'd1);
    chk("flush C11 ADD result", bus.ALU_result, 32'd7);
    chk("flush C11 stall", 32'(bus.ex_stall), 32'd0);
    @(posedge clk); #1; idle_inputs();
    seen = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (bus.result_valid) seen++; end
    chk("flushed DIV never valid", seen, 0);

    // flush in the DONE cycle suppresses the result
    @(posedge clk); #1;
    drive_mop(3'd0, 32'd7, 32'hFFFFFFFD, 2'b00, 0);
    for (int k = 0; k < 17; k++) begin @(posedge clk); #1; end
    bus.ex_flush = 1'b1;
    @(negedge clk);
    chk("flush over DONE valid", 32'(bus.result_valid), 32'd0);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    chk("after flush DONE valid", 32'(bus.result_valid), 32'd0);
    chk("after flush DONE stall", 32'(bus.ex_stall), 32'd0);

    // reset mid-MUL aborts silently
    @(posedge clk); #1;
    drive_mop(3'd0, 32'd7, 32'd3, 2'b00, 0);
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("mid-op reset stall", 32'(bus.ex_stall), 32'd0);
    chk("mid-op reset valid", 32'(bus.result_valid), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.result_valid || bus.ex_stall) seen++; end
    chk("no activity after reset", seen, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.inst = enc(7'h00, 3'd0, R);
    bus.read_data_1 = 32'd20; bus.read_data_2 = 32'd22;
    @(negedge clk);
    chk("post-reset ADD", bus.ALU_result, 32'd42);
    chk("post-reset ADD valid", 32'(bus.result_valid), 32'd1);
    @(posedge clk); #1; idle_inputs();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
